// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window builder: default pixel width and the
// fill-counter geometry (2-bit counter saturating at 3).
package sobel_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned FILL_W     = 2;
   localparam logic [FILL_W-1:0] FILL_SAT = 2'd3;
   localparam logic [FILL_W-1:0] FILL_RDY = 2'd2;

   function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] c);
      return (c == FILL_SAT) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/sobel_row_shift.sv
// One window row: 3-tap shift register that moves left when en is high.
// tap0 is the oldest pixel, tap2 the newest.
module sobel_row_shift #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] tap0,
   output logic [DATA_W-1:0] tap1,
   output logic [DATA_W-1:0] tap2
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap0 <= '0;
         tap1 <= '0;
         tap2 <= '0;
      end else if (en) begin
         tap0 <= tap1;
         tap1 <= tap2;
         tap2 <= din;
      end
   end

endmodule

// File: rtl/sobel_data_modulate.sv
// Builds a registered 3x3 pixel window from incoming columns, flagging done_o
// once three valid columns are present. Define SOBEL_DM_LINE_FLUSH_EN to reset
// the fill count on every stall so each line needs three fresh columns.
module sobel_data_modulate
   import sobel_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d0_i,
   input  logic [DATA_W-1:0] d1_i,
   input  logic [DATA_W-1:0] d2_i,
   input  logic              done_i,
   output logic [DATA_W-1:0] d0_o,
   output logic [DATA_W-1:0] d1_o,
   output logic [DATA_W-1:0] d2_o,
   output logic [DATA_W-1:0] d3_o,
   output logic [DATA_W-1:0] d4_o,
   output logic [DATA_W-1:0] d5_o,
   output logic [DATA_W-1:0] d6_o,
   output logic [DATA_W-1:0] d7_o,
   output logic [DATA_W-1:0] d8_o,
   output logic              done_o
);

   logic [FILL_W-1:0] fill;

   sobel_row_shift #(.DATA_W(DATA_W)) u_row0 (
      .clk(clk), .rst(rst), .en(done_i), .din(d0_i),
      .tap0(d0_o), .tap1(d1_o), .tap2(d2_o)
   );

   sobel_row_shift #(.DATA_W(DATA_W)) u_row1 (
      .clk(clk), .rst(rst), .en(done_i), .din(d1_i),
      .tap0(d3_o), .tap1(d4_o), .tap2(d5_o)
   );

   sobel_row_shift #(.DATA_W(DATA_W)) u_row2 (
      .clk(clk), .rst(rst), .en(done_i), .din(d2_i),
      .tap0(d6_o), .tap1(d7_o), .tap2(d8_o)
   );

   // done_o uses the pre-edge count, so it rises on the edge capturing column 3
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill   <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= done_i && (fill >= FILL_RDY);
         if (done_i) begin
            fill <= fill_inc(fill);
         end else begin
`ifdef SOBEL_DM_LINE_FLUSH_EN
            fill <= '0;
`else
            fill <= fill;
`endif
         end
      end
   end

endmodule

// File: tb/tb_sobel_data_modulate.sv
// Scoreboard bench for sobel_data_modulate: stimulus pushes hand-derived
// expected windows, a negedge monitor pops and compares them.
module tb_sobel_data_modulate;

   typedef struct packed {
      logic [8:0][7:0] win;
      logic            done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d0_i = '0, d1_i = '0, d2_i = '0;
   logic       done_i = 1'b0;
   logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
   logic       done_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   exp_t        sb[$];

   sobel_data_modulate #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .d0_i(d0_i), .d1_i(d1_i), .d2_i(d2_i), .done_i(done_i),
      .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o),
      .d3_o(d3_o), .d4_o(d4_o), .d5_o(d5_o),
      .d6_o(d6_o), .d7_o(d7_o), .d8_o(d8_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0][7:0] actual_win();
      logic [8:0][7:0] a;
      a[0] = d0_o; a[1] = d1_o; a[2] = d2_o;
      a[3] = d3_o; a[4] = d4_o; a[5] = d5_o;
      a[6] = d6_o; a[7] = d7_o; a[8] = d8_o;
      return a;
   endfunction

   // Window after the column with index k was captured, stream begun at s.
   function automatic logic [8:0][7:0] exp_win(input int k, input int s);
      logic [8:0][7:0] w;
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 3; j++) begin
            int v;
            v = k - 2 + j;
            w[r*3+j] = (v >= s) ? 8'(v + r) : 8'd0;
         end
      end
      return w;
   endfunction

   task automatic compare(input string name, input exp_t e);
      logic [8:0][7:0] a;
      a = actual_win();
      n_tests++;
      if (a !== e.win || done_o !== e.done) begin
         n_fail++;
         $display("FAIL %s: got win=%h done=%b, want win=%h done=%b",
                  name, a, done_o, e.win, e.done);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) compare("edge", sb.pop_front());
   end

   task automatic step(input logic di, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input exp_t e);
      done_i = di; d0_i = a; d1_i = b; d2_i = c;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic feed(input int i, input int s, input logic dexp);
      exp_t e;
      e.win  = exp_win(i, s);
      e.done = dexp;
      step(1'b1, 8'(i), 8'(i + 1), 8'(i + 2), e);
   endtask

   initial begin
      exp_t z, h;
      z.win = '0; z.done = 1'b0;

      // asynchronous reset with inputs all ones, no clock edge involved
      @(negedge clk); #1;
      d0_i = 8'hFF; d1_i = 8'hFF; d2_i = 8'hFF; done_i = 1'b1;
      rst = 1'b0;
      #1;
      compare("reset_async", z);
      @(negedge clk); #1;
      compare("reset_held", z);
      rst = 1'b1;

      // fill and streaming to i=10
      for (int i = 1; i <= 10; i++) feed(i, 1, i >= 3);

      // stall for two edges, inputs changed to show they are ignored
      h.win = exp_win(10, 1); h.done = 1'b0;
      step(1'b0, 8'hEE, 8'hEE, 8'hEE, h);
      step(1'b0, 8'hEE, 8'hEE, 8'hEE, h);

      // resume and stream to i=30
      for (int i = 11; i <= 30; i++) begin
`ifdef SOBEL_DM_LINE_FLUSH_EN
         feed(i, 1, i >= 13);
`else
         feed(i, 1, 1'b1);
`endif
      end

      // mid-stream reset after i=5
      rst = 1'b0; #1; rst = 1'b1;
      for (int i = 1; i <= 5; i++) feed(i, 1, i >= 3);
      rst = 1'b0;
      #1;
      compare("reset_mid", z);
      rst = 1'b1;
      for (int i = 20; i <= 22; i++) feed(i, 20, i >= 22);

      // drain the scoreboard with a bounded wait
      for (int c = 0; c < 10 && sb.size() > 0; c++) @(negedge clk);
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sobel_data_modulate.md
SOBEL_DATA_MODULATE -- requirements
Module: sobel_data_modulate

Interface
REQ-001 Parameter: DATA_W, default 8, pixel width in bits for every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low.
REQ-004 Port: d0_i  input  DATA_W  column pixel for window row 0 (top row).
REQ-005 Port: d1_i  input  DATA_W  column pixel for window row 1 (middle row).
REQ-006 Port: d2_i  input  DATA_W  column pixel for window row 2 (bottom row).
REQ-007 Port: done_i  input  1  column-valid strobe; high means d0_i..d2_i carry one new column this cycle.
REQ-008 Port: d0_o..d8_o  output  DATA_W each  3x3 window, row-major: d0 d1 d2 / d3 d4 d5 / d6 d7 d8; left column oldest, right column newest.
REQ-009 Port: done_o  output  1  window-valid strobe; high means d0_o..d8_o form a complete window of three valid columns.

Function
REQ-010 Each row SHALL be a 3-stage shift register; row r input feeds its rightmost tap.
REQ-011 On a clk edge with done_i=1, every row SHALL shift left one position: the leftmost tap takes the middle tap, the middle tap takes the rightmost tap, and the rightmost tap captures the row input. Row 0 uses d0_i, row 1 uses d1_i, row 2 uses d2_i.
REQ-012 On a clk edge with done_i=0, all window registers SHALL hold their values.
REQ-013 All outputs SHALL be driven directly from registers, with no combinational path from any input.
REQ-014 Latency: a column captured at edge N SHALL appear on d2_o/d5_o/d8_o after edge N.
REQ-015 A 2-bit fill counter SHALL increment by one on each edge with done_i=1 and saturate at 3.
REQ-016 done_o SHALL be registered as (done_i AND fill counter >= 2), evaluated at each edge.
REQ-017 done_o SHALL therefore rise at the same edge that captures the third column.
REQ-018 done_o SHALL stay high while done_i remains 1 at every subsequent edge.
REQ-019 done_o SHALL fall at the first edge where done_i=0.
REQ-020 Data SHALL be passed through unmodified, with no arithmetic or truncation.
REQ-021 Default behaviour when done_i is deasserted (stall): the fill counter SHALL hold. On resume, done_o SHALL rise at the first edge with done_i=1 if the counter is 3.

Reset
REQ-022 While rst=0, all window registers, the fill counter and done_o SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 Reset asserted mid-stream SHALL discard the partial window; after release, three new columns are required before done_o rises.

Configuration
REQ-024 Macro SOBEL_DM_LINE_FLUSH_EN compiles in line-flush behaviour.
REQ-025 When SOBEL_DM_LINE_FLUSH_EN is defined, an edge with done_i=0 SHALL clear the fill counter to 0, so each new line needs three fresh columns. Window registers still hold.
REQ-026 When SOBEL_DM_LINE_FLUSH_EN is not defined, the stall behaviour of REQ-021 SHALL apply.

Structure
REQ-027 Shared package sobel_pkg SHALL hold the DATA_W default constant and the fill-counter width/saturation constant (3).
REQ-028 Sub-module sobel_row_shift (one 3-tap enabled shift row, async active-low reset) SHALL be instantiated three times, once per row.

Verification
REQ-029 Reset check: drive rst=0 with inputs 8'hFF -> all nine outputs 0 and done_o=0, asynchronously.
REQ-030 Fill check: release reset, then drive done_i=1 with d0_i=i, d1_i=i+1, d2_i=i+2 for i=1,2,3 on consecutive edges.
- After the edge capturing i=2: done_o=0.
- After the edge capturing i=3: d0..d8_o = 1,2,3 / 2,3,4 / 3,4,5 and done_o=1.
REQ-031 Streaming check: continue the REQ-030 pattern to i=30.
- After capturing i=k (k>=3): row 0 = k-2,k-1,k; row 1 = k-1,k,k+1; row 2 = k,k+1,k+2.
- done_o stays 1 throughout.
REQ-032 Stall check: after i=10, hold done_i=0 for 2 edges, then resume at i=11.
- During the stall: window holds 8..12 values; done_o=0.
- Without SOBEL_DM_LINE_FLUSH_EN: done_o=1 after the edge capturing i=11.
- With SOBEL_DM_LINE_FLUSH_EN: done_o=1 only after the edge capturing i=13.
REQ-033 Mid-stream reset check: assert rst=0 after i=5, release, then feed i=20..22 -> done_o=0 until the edge capturing i=22. The window then shows 20,21,22 / 21,22,23 / 22,23,24.
